// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes and SRAM bus of the
// pixel SRAM arbiter; slave = arbiter side, master = environment.
interface sram_arbiter_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 eng_req;
    logic                 eng_we;
    logic [ADDR_BITS-1:0] eng_addr;
    logic [DATA_BITS-1:0] eng_wdata;
    logic                 eng_lock;
    logic                 eng_gnt;
    logic                 eng_rvalid;
    logic [DATA_BITS-1:0] eng_rdata;

    logic                 jtg_req;
    logic                 jtg_we;
    logic [ADDR_BITS-1:0] jtg_addr;
    logic [DATA_BITS-1:0] jtg_wdata;
    logic                 jtg_gnt;
    logic                 jtg_rvalid;
    logic [DATA_BITS-1:0] jtg_rdata;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;
    logic [1:0]           owner;

    modport slave (
        input  eng_req, eng_we, eng_addr, eng_wdata, eng_lock,
        output eng_gnt, eng_rvalid, eng_rdata,
        input  jtg_req, jtg_we, jtg_addr, jtg_wdata,
        output jtg_gnt, jtg_rvalid, jtg_rdata,
        output mem_we, mem_addr, mem_wdata, owner,
        input  mem_rdata
    );

    modport master (
        output eng_req, eng_we, eng_addr, eng_wdata, eng_lock,
        input  eng_gnt, eng_rvalid, eng_rdata,
        output jtg_req, jtg_we, jtg_addr, jtg_wdata,
        input  jtg_gnt, jtg_rvalid, jtg_rdata,
        input  mem_we, mem_addr, mem_wdata, owner,
        output mem_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: engine/JTAG arbiter for the shared pixel SRAM.
// Define ARB_STATS_EN to add per-requester grant counters.
module sram_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        aclr_n,
`ifdef ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] eng_cnt,
    output logic [15:0] jtg_cnt,
`endif
    sram_arbiter_if.slave bus
);
    typedef enum logic {
        SRC_ENG = 1'b0,
        SRC_JTG = 1'b1
    } src_e;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    src_e                 rr_last_q, rr_last_d;
    src_e                 rd_tag_q, rd_tag_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] eng_rdata_q, jtg_rdata_q;
    logic                 gnt_e, gnt_j, we_c;
    logic                 eng_rv, jtg_rv;

    // Grant decision: lock priority with starvation escape, else RR.
    always_comb begin
        gnt_e = 1'b0;
        gnt_j = 1'b0;
        if (aclr_n) begin
            if (bus.eng_lock) begin
                if (bus.eng_req &&
                    !(bus.jtg_req && wait_cnt_q == WAIT_MAX))
                    gnt_e = 1'b1;
                else if (bus.jtg_req)
                    gnt_j = 1'b1;
            end else if (bus.eng_req && bus.jtg_req) begin
                if (rr_last_q == SRC_JTG)
                    gnt_e = 1'b1;
                else
                    gnt_j = 1'b1;
            end else begin
                gnt_e = bus.eng_req;
                gnt_j = bus.jtg_req;
            end
        end
    end

    // SRAM bus mux and next state of the arbitration registers.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_c       = 1'b0;
        rr_last_d  = rr_last_q;
        wait_cnt_d = wait_cnt_q;
        if (gnt_e) begin
            addr_d    = bus.eng_addr;
            wdata_d   = bus.eng_wdata;
            we_c      = bus.eng_we;
            rr_last_d = SRC_ENG;
        end else if (gnt_j) begin
            addr_d    = bus.jtg_addr;
            wdata_d   = bus.jtg_wdata;
            we_c      = bus.jtg_we;
            rr_last_d = SRC_JTG;
        end
        if (gnt_j || !bus.jtg_req)
            wait_cnt_d = 8'd0;
        else if (wait_cnt_q != WAIT_MAX)
            wait_cnt_d = wait_cnt_q + 8'd1;
        rd_pend_d = (gnt_e || gnt_j) && !we_c;
        rd_tag_d  = gnt_j ? SRC_JTG : SRC_ENG;
    end

    // Arbitration state and last-granted bus values.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rr_last_q  <= SRC_JTG;
            wait_cnt_q <= 8'd0;
            rd_pend_q  <= 1'b0;
            rd_tag_q   <= SRC_ENG;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rr_last_q  <= rr_last_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_tag_q   <= rd_tag_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign eng_rv = rd_pend_q && (rd_tag_q == SRC_ENG);
    assign jtg_rv = rd_pend_q && (rd_tag_q == SRC_JTG);

    // Read data is returned straight from the SRAM in the rvalid
    // cycle and held per requester until its next return.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            eng_rdata_q <= '0;
            jtg_rdata_q <= '0;
        end else begin
            if (eng_rv) eng_rdata_q <= bus.mem_rdata;
            if (jtg_rv) jtg_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.eng_gnt    = gnt_e;
    assign bus.jtg_gnt    = gnt_j;
    assign bus.owner      = {gnt_j, gnt_e};
    assign bus.mem_we     = we_c;
    assign bus.mem_addr   = addr_d;
    assign bus.mem_wdata  = wdata_d;
    assign bus.eng_rvalid = eng_rv;
    assign bus.jtg_rvalid = jtg_rv;
    assign bus.eng_rdata  = eng_rv ? bus.mem_rdata : eng_rdata_q;
    assign bus.jtg_rdata  = jtg_rv ? bus.mem_rdata : jtg_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] eng_cnt_q, jtg_cnt_q;

    // Grant counters; clear wins over increment.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            eng_cnt_q <= 16'd0;
            jtg_cnt_q <= 16'd0;
        end else if (stats_clr) begin
            eng_cnt_q <= 16'd0;
            jtg_cnt_q <= 16'd0;
        end else begin
            if (gnt_e) eng_cnt_q <= eng_cnt_q + 16'd1;
            if (gnt_j) jtg_cnt_q <= jtg_cnt_q + 16'd1;
        end
    end

    assign eng_cnt = eng_cnt_q;
    assign jtg_cnt = jtg_cnt_q;
`endif
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port pixel SRAM.
- Requesters: the interpolation engine (control_unit) and the JTAG front-end (connect).
- Replaces the plain busy-driven address/data mux in front of mem_sram_simple.
- Adds a req/gnt handshake, read-data return routing, a bounded-starvation guarantee for JTAG while the engine is busy, and a write-collision-free single-beat protocol.

Parameters:
- ADDR_BITS, 8: SRAM address width on all address ports.
- DATA_BITS, 8: SRAM data width.
- MAX_WAIT, 15: max consecutive cycles a pending JTAG request is held off while eng_lock=1 (range 1..255).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- aclr_n  in  1  asynchronous active-low reset.
- eng_req  in  1  engine access request; held until eng_gnt.
- eng_we  in  1  engine access is a write (1) or read (0).
- eng_addr  in  ADDR_BITS  engine address.
- eng_wdata  in  DATA_BITS  engine write data.
- eng_lock  in  1  engine busy; engine gets priority while high.
- eng_gnt  out  1  engine access issued this cycle.
- eng_rvalid  out  1  engine read data valid.
- eng_rdata  out  DATA_BITS  engine read data.
- jtg_req  in  1  JTAG access request.
- jtg_we  in  1  JTAG write/read.
- jtg_addr  in  ADDR_BITS  JTAG address.
- jtg_wdata  in  DATA_BITS  JTAG write data.
- jtg_gnt  out  1  JTAG access issued this cycle.
- jtg_rvalid  out  1  JTAG read data valid.
- jtg_rdata  out  DATA_BITS  JTAG read data.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_BITS  SRAM address.
- mem_wdata  out  DATA_BITS  SRAM write data.
- mem_rdata  in  DATA_BITS  SRAM read data, registered, valid 1 cycle after address.
- owner  out  2  current cycle grant: 00 none, 01 engine, 10 JTAG.

Behaviour:
- Reset values: all gnt/rvalid/mem_we low; mem_addr and mem_wdata 0; owner 00; rr_last=JTG so engine wins first tie; wait_cnt 0; rdata outputs 0.
- Single-beat accesses. A requester keeps req/we/addr/wdata stable until it sees gnt high at a rising edge; that edge completes the access. At most one gnt per cycle.
- Grant decision is combinational from req inputs plus registered state; mem_* = mux of the granted requester. With no grant: mem_we=0, mem_addr/mem_wdata hold the last granted values.
- Priority with eng_lock=1:
  - Engine wins whenever eng_req=1, unless wait_cnt==MAX_WAIT and jtg_req=1; then JTAG wins that cycle.
  - JTAG wins when eng_req=0.
- Priority with eng_lock=0: round-robin on conflict. The winner is the requester not equal to rr_last; rr_last updates to the winner on every grant.
- wait_cnt (8-bit):
  - Increments each cycle jtg_req=1 and jtg_gnt=0, saturating at MAX_WAIT.
  - Clears on jtg_gnt or when jtg_req=0.
- Read return:
  - 1-bit tag register captures the owner of a granted read.
  - The next cycle asserts the matching rvalid for exactly 1 cycle, with rdata = mem_rdata.
  - Registered xxx_rdata holds until that requester's next rvalid.
  - Writes never produce rvalid.
- Back-to-back grants to the same or alternating requesters are allowed every cycle; pipelined read returns stay ordered.
- eng_lock falling while a JTAG request is pending: round-robin applies from the next cycle; wait_cnt keeps counting until grant.
- Reset asserted mid-access: everything returns asynchronously to reset values; no in-flight rvalid is emitted after reset release.

Optional Feature:
- ARB_STATS_EN.
- Defined: adds output ports eng_cnt[15:0] and jtg_cnt[15:0], plus input stats_clr. Each counter increments on its requester's grant and wraps at 0xFFFF→0. stats_clr=1 zeroes both counters, taking precedence over increment. Both reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then JTAG write addr 0x10 data 0xA5, then JTAG read 0x10 → jtg_gnt 1 cycle each; mem_we=1 only on the write; jtg_rvalid 1 cycle after the read grant with jtg_rdata=0xA5; eng_rvalid stays 0.
- eng_lock=0, both requesting reads every cycle, first conflict after reset → grants alternate E,J,E,J; owner follows 01,10,01,10; each rvalid goes to the correct port with the correct data.
- eng_lock=1, eng_req held continuously, jtg_req raised at cycle 0, MAX_WAIT=15 → jtg_gnt exactly at cycle 15; engine regains grant at cycle 16; wait_cnt back to 0.
- eng_lock=1, eng_req=0, jtg_req=1 → immediate jtg_gnt; wait_cnt never leaves 0.
- Engine read granted, aclr_n pulsed low on the following cycle → eng_rvalid never asserts; all outputs at reset values.
- With ARB_STATS_EN: 5 engine grants and 3 JTAG grants → eng_cnt=5, jtg_cnt=3; stats_clr on the same cycle as a grant → the affected counter reads 0.
